// File: rtl/cram_diag_if.sv
// rtl/cram_diag_if.sv - diagnostic load/readback port of the microcode store
interface cram_diag_if #(
    parameter int ADDR_BITS = 12,
    parameter int CHUNK     = 12
);
    logic [1:0]           diag_cmd;
    logic [ADDR_BITS-1:0] diag_addr;
    logic                 diag_cmd_valid;
    logic                 diag_cmd_ready;
    logic [CHUNK-1:0]     diag_wdata;
    logic                 diag_wvalid;
    logic                 diag_wready;
    logic [CHUNK-1:0]     diag_rdata;
    logic                 diag_rvalid;
    logic                 diag_rready;
    logic                 diag_busy;

    modport master (
        output diag_cmd, diag_addr, diag_cmd_valid, diag_wdata, diag_wvalid, diag_rready,
        input  diag_cmd_ready, diag_wready, diag_rdata, diag_rvalid, diag_busy
    );

    modport slave (
        input  diag_cmd, diag_addr, diag_cmd_valid, diag_wdata, diag_wvalid, diag_rready,
        output diag_cmd_ready, diag_wready, diag_rdata, diag_rvalid, diag_busy
    );
endinterface

// File: rtl/cram_store.sv
// rtl/cram_store.sv - parity-protected microcode store with CR and chunked diagnostic port
module cram_store #(
    parameter int WIDTH     = 84,
    parameter int ADDR_BITS = 12,
    parameter int CHUNK     = 12,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] cradr,
    input  logic                 adv,
    output logic [0:WIDTH-1]     cr,
    output logic                 cr_par_err,
    output logic                 par_err_sticky,
    input  logic                 clr_err,
    cram_diag_if.slave           diag
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int TOT    = NCHUNK * CHUNK;
    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int CW     = $clog2(NCHUNK + 1);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, RFETCH, DRAIN} state_t;

    logic [0:WIDTH-1]     mem     [DEPTH];
    logic                 par_mem [DEPTH];

    state_t               state_q;
    logic [0:TOT-1]       asm_q;
    logic [0:TOT-1]       sh_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [CW-1:0]        cnt_q;
    logic                 rvalid_q;
    logic                 cr_par;
    logic                 cr_v;

    logic [0:WIDTH-1]     wr_word;
    logic                 wr_par;
    logic [0:TOT-1]       rd_word;
    logic                 abort;
    logic                 wr_en;
    logic                 last_chunk;

    always_comb begin
        wr_word = asm_q[0:WIDTH-1];
        wr_par  = ~^wr_word;
        rd_word = '0;
        rd_word[0:WIDTH-1] = mem[addr_q];
    end

    assign abort      = diag.diag_cmd_valid && (diag.diag_cmd == 2'b11) && (state_q != IDLE);
    // An abort landing on the WRITE cycle still discards the word.
    assign wr_en      = (state_q == WRITE) && !abort;
    assign last_chunk = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q]     <= wr_word;
            par_mem[addr_q] <= wr_par;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr             <= '0;
            cr_par         <= 1'b0;
            cr_v           <= 1'b0;
            par_err_sticky <= 1'b0;
        end else begin
            if (adv) begin
                if (wr_en && (cradr == addr_q)) begin
                    cr     <= wr_word;
                    cr_par <= wr_par;
                end else begin
                    cr     <= mem[cradr];
                    cr_par <= par_mem[cradr];
                end
                cr_v <= 1'b1;
            end
            if (cr_par_err)
                par_err_sticky <= 1'b1;
            else if (clr_err)
                par_err_sticky <= 1'b0;
        end
    end

    assign cr_par_err = PARITY_EN && cr_v && !(^{cr, cr_par});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            asm_q    <= '0;
            sh_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else if (abort) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (diag.diag_cmd_valid && diag.diag_cmd == 2'b01) begin
                        addr_q  <= diag.diag_addr;
                        cnt_q   <= '0;
                        state_q <= FILL;
                    end else if (diag.diag_cmd_valid && diag.diag_cmd == 2'b10) begin
                        addr_q  <= diag.diag_addr;
                        state_q <= RFETCH;
                    end
                end
                FILL: begin
                    if (diag.diag_wvalid) begin
                        asm_q <= {asm_q[CHUNK:TOT-1], diag.diag_wdata};
                        cnt_q <= cnt_q + 1'b1;
                        if (last_chunk)
                            state_q <= WRITE;
                    end
                end
                WRITE: state_q <= IDLE;
                RFETCH: begin
                    sh_q     <= rd_word;
                    cnt_q    <= '0;
                    rvalid_q <= 1'b1;
                    state_q  <= DRAIN;
                end
                DRAIN: begin
                    if (diag.diag_rready) begin
                        sh_q  <= {sh_q[CHUNK:TOT-1], {CHUNK{1'b0}}};
                        cnt_q <= cnt_q + 1'b1;
                        if (last_chunk) begin
                            rvalid_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign diag.diag_cmd_ready = (state_q == IDLE);
    assign diag.diag_busy      = (state_q != IDLE);
    assign diag.diag_wready    = (state_q == FILL);
    assign diag.diag_rvalid    = rvalid_q;
    assign diag.diag_rdata     = sh_q[0:CHUNK-1];
endmodule
